// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared ALU/MDU op codes, widths and MDU state encoding
package core_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ADD    = 5'b00000;
    localparam alu_op_t SUB    = 5'b00001;
    localparam alu_op_t SLL    = 5'b00010;
    localparam alu_op_t SLT    = 5'b00011;
    localparam alu_op_t SLTU   = 5'b00100;
    localparam alu_op_t XOR    = 5'b00101;
    localparam alu_op_t SRL    = 5'b00110;
    localparam alu_op_t SRA    = 5'b00111;
    localparam alu_op_t OR     = 5'b01000;
    localparam alu_op_t AND_   = 5'b01001;
    localparam alu_op_t MUL    = 5'b01010;
    localparam alu_op_t MULH   = 5'b01011;
    localparam alu_op_t MULHSU = 5'b01100;
    localparam alu_op_t MULHU  = 5'b01101;
    localparam alu_op_t DIV    = 5'b01110;
    localparam alu_op_t DIVU   = 5'b01111;
    localparam alu_op_t REM    = 5'b10000;
    localparam alu_op_t REMU   = 5'b10001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_t;

    function automatic logic is_mop(input alu_op_t op);
        return (op >= MUL) && (op <= REMU);
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return (op >= DIV) && (op <= REMU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: add-shift multiply or restoring divide step
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic                i_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [2*XLEN-1:0]   i_opa,
    input  logic [XLEN-1:0]     i_opb,
    output logic [2*XLEN-1:0]   o_acc,
    output logic [2*XLEN-1:0]   o_opa,
    output logic [XLEN-1:0]     o_opb
);

    logic            w_fits;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem;

    // Divide: i_acc = {remainder, dividend}; the shifted-out dividend bit joins the remainder.
    always_comb begin
        w_fits = i_acc[2*XLEN-1:XLEN-1] >= {1'b0, i_opa[XLEN-1:0]};
        w_diff = i_acc[2*XLEN-2:XLEN-1] - i_opa[XLEN-1:0];
        w_rem  = w_fits ? w_diff : i_acc[2*XLEN-2:XLEN-1];
        if (i_div) begin
            o_acc = {w_rem, i_acc[XLEN-2:0], w_fits};
            o_opa = i_opa;
            o_opb = i_opb;
        end else begin
            o_acc = i_opb[0] ? (i_acc + i_opa) : i_acc;
            o_opa = {i_opa[2*XLEN-2:0], 1'b0};
            o_opb = {1'b0, i_opb[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer
// Optional MDU_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_seq
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  alu_op_t         alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    alu_op_t           r_op;
    logic              r_sign_a, r_sign_b;
    logic [2*XLEN-1:0] r_acc, r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_op_div, w_sa, w_sb, w_special, w_calc_last, w_r_div;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res, w_fix_res;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_step_acc, w_step_opa;
    logic [XLEN-1:0]   w_step_opb;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && is_mop(alu_op);
    assign w_op_div = is_div_op(alu_op);
    assign w_r_div  = is_div_op(r_op);

    always_comb begin
        w_sa = a[XLEN-1] && ((alu_op == MULH) || (alu_op == MULHSU) ||
                             (alu_op == DIV)  || (alu_op == REM));
        w_sb = b[XLEN-1] && ((alu_op == MULH) || (alu_op == DIV) || (alu_op == REM));
        w_mag_a = w_sa ? -a : a;
        w_mag_b = w_sb ? -b : b;
        w_special     = 1'b0;
        w_special_res = '0;
        // Zero divisor and signed overflow never enter the iteration loop.
        if (w_op_div && (b == '0)) begin
            w_special     = 1'b1;
            w_special_res = ((alu_op == DIV) || (alu_op == DIVU)) ? '1 : a;
        end else if (((alu_op == DIV) || (alu_op == REM)) && (a == MIN_NEG) && (b == '1)) begin
            w_special     = 1'b1;
            w_special_res = (alu_op == DIV) ? MIN_NEG : '0;
        end
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .i_div (w_r_div),
        .i_acc (r_acc),
        .i_opa (r_opa),
        .i_opb (r_opb),
        .o_acc (w_step_acc),
        .o_opa (w_step_opa),
        .o_opb (w_step_opb)
    );

`ifdef MDU_EARLY_OUT_EN
    assign w_calc_last = (r_cnt == CNT_W'(XLEN-1)) || (!w_r_div && (w_step_opb == '0));
`else
    assign w_calc_last = (r_cnt == CNT_W'(XLEN-1));
`endif

    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        case (r_op)
            MUL:                 w_fix_res = w_prod[XLEN-1:0];
            MULH, MULHSU, MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            DIV, DIVU:           w_fix_res = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0]
                                                                  : r_acc[XLEN-1:0];
            REM, REMU:           w_fix_res = r_sign_a ? -r_acc[2*XLEN-1:XLEN]
                                                      : r_acc[2*XLEN-1:XLEN];
            default:             w_fix_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_calc_last) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= ADD;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= alu_op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_acc    <= w_op_div ? {{XLEN{1'b0}}, w_mag_a} : '0;
            r_opa    <= {{XLEN{1'b0}}, w_op_div ? w_mag_b : w_mag_a};
            r_opb    <= w_mag_b;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_step_acc;
            r_opa <= w_step_opa;
            r_opb <= w_step_opb;
        end else if (r_state == S_FIX) begin
            r_result <= w_fix_res;
        end
    end

    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq
module tb_mdu_seq;
    import core_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

`ifdef MDU_EARLY_OUT_EN
    localparam int MUL_LAT = -1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    alu_op_t     alu_op;
    logic [31:0] a, b, result;
    logic        busy, done;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_done  = 0;
    sb_t sb_q[$];
    sb_t mon_e;

    mdu_seq u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      sp;
        int          sq;
        case (op)
            MUL:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            MULH:   begin sp = longint'($signed(x)) * longint'($signed(y)); return sp[63:32]; end
            MULHSU: begin sp = longint'($signed(x)) * longint'({32'b0, y}); return sp[63:32]; end
            MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                sq = $signed(x) / $signed(y);
                return sq;
            end
            DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                sq = $signed(x) % $signed(y);
                return sq;
            end
            REMU:   return (y == 0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    // Caller is #1 after a rising edge; start is sampled at the next edge (E).
    task automatic run_op(input string tag, input alu_op_t op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                          output int lat, output int nbusy);
        sb_q.push_back('{tag: tag, exp: exp});
        start = 1'b1; alu_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (busy) check("busy_done_excl", busy, 1'b0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.tag, result, mon_e.exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, nd;
        alu_op_t     rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; alu_op = ADD; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul", MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, lat, nb);
        check("mul_busy_cycles", nb, 33);
        run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, lat, nb);
        run_op("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT, lat, nb);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, lat, nb);

        run_op("div", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, DIV_LAT, lat, nb);
        run_op("rem", REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, DIV_LAT, lat, nb);
        run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, lat, nb);
        run_op("remu", REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, lat, nb);

        run_op("divu_by0", DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, SPC_LAT, lat, nb);
        run_op("remu_by0", REMU, 32'h1234, 32'h0, 32'h1234, SPC_LAT, lat, nb);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, lat, nb);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT, lat, nb);

        // Second start mid-CALC must leave the running divide untouched.
        sb_q.push_back('{tag: "div_ignore", exp: 32'hFFFF_FFFD});
        start = 1'b1; alu_op = DIV; a = 32'hFFFF_FFF9; b = 32'h2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; alu_op = MUL; a = 32'h3; b = 32'h5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("div_ignore_lat", lat, DIV_LAT);

        @(posedge clk); #1;
        nd = n_done;
        start = 1'b1; alu_op = ADD; a = 32'h1; b = 32'h2;
        @(posedge clk); #1;
        start = 1'b0;
        check("add_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("add_no_done", n_done, nd);
        check("result_hold", result, 32'hFFFF_FFFD);

        for (int i = 0; i < 12; i++) begin
            rop = alu_op_t'(MUL + 5'($urandom_range(0, 7)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), -1, lat, nb);
        end
        run_op("remu_pre_rst", REMU, 32'h1234, 32'h0, 32'h1234, SPC_LAT, lat, nb);

        start = 1'b1; alu_op = MULHU; a = 32'h0000_FFFF; b = 32'h8000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        nd = n_done;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", n_done, nd);

`ifdef MDU_EARLY_OUT_EN
        run_op("early_mul", MUL, 32'd5, 32'd3, 32'd15, -1, lat, nb);
        check("early_lat_le3", lat <= 3, 1'b1);
        run_op("early_b0", MUL, 32'd5, 32'd0, 32'd0, 2, lat, nb);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
